// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants, types and helpers for the PWM block
//
// Purpose : register offsets, counter width, reset value, register
//           select type and byte-strobe merge helper.
// Ports   : none (package).
package pwm_pkg;

   localparam int          CNT_W   = 16;
   localparam logic [31:0] CFG_OFF = 32'h0;
   localparam logic [31:0] CNT_OFF = 32'h4;
   localparam logic [31:0] CFG_RST = 32'h0;

   typedef enum logic {
      REG_CFG = 1'b0,
      REG_CNT = 1'b1
   } reg_sel_e;

   typedef enum logic {
      BUS_IDLE = 1'b0,
      BUS_ACK  = 1'b1
   } bus_state_e;

   // Only address bit 2 distinguishes the two registers.
   function automatic reg_sel_e decode(input logic addr_b2);
      return (addr_b2 == CNT_OFF[2]) ? REG_CNT : REG_CFG;
   endfunction

   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/pwm_if.sv
// rtl/pwm_if.sv - native valid/ready memory bus between master and PWM block
//
// Purpose : groups the bus request/response signals.
// Signals : mem_valid/mem_addr/mem_wdata/mem_wstrb (master -> slave),
//           mem_ready/mem_rdata (slave -> master).
interface pwm_if;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/pwm_counter.sv
// rtl/pwm_counter.sv - active duty/period registers, period counter and compare
//
// Purpose : loads the active settings from the shadow at each period
//           boundary (or every cycle while the active period is 0), runs
//           the free-running counter and registers the PWM compare.
// Ports   : clk, rst_n           clock, synchronous active-low reset
//           shadow_duty_i       shadow duty value
//           shadow_period_i     shadow period value
//           cnt_o               live counter
//           pwm_o               registered PWM output
module pwm_counter
   import pwm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] shadow_duty_i,
   input  logic [CNT_W-1:0] shadow_period_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             pwm_o
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             pwm_q, pwm_d;
   logic             idle;
   logic             wrap;

   always_comb begin
      cnt_d    = cnt_q;
      duty_d   = duty_q;
      period_d = period_q;
      idle     = (period_q == '0);
      wrap     = !idle && (cnt_q == period_q - ONE);

      if (idle || wrap) cnt_d = '0;
      else              cnt_d = cnt_q + ONE;

      // Loading only at the boundary keeps every period glitch-free.
      if (idle || wrap) begin
         duty_d   = shadow_duty_i;
         period_d = shadow_period_i;
      end

      pwm_d = !idle && (cnt_q < duty_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         duty_q   <= '0;
         period_q <= '0;
         pwm_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         duty_q   <= duty_d;
         period_q <= period_d;
         pwm_q    <= pwm_d;
      end
   end

   assign cnt_o = cnt_q;
   assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm.sv
// rtl/pwm.sv - memory-mapped PWM generator, top level
//
// Purpose : bus slave with CFG shadow register ({duty, period}) at offset 0
//           and read-only live counter at offset 4; drives one PWM pin.
// Ports   : clk, rst_n   clock, synchronous active-low reset
//           bus          pwm_if.slave valid/ready memory bus
//           pwm_out      registered PWM output
// Macro   : PWM_READBACK_EN - when defined, reads return CFG/CNT; when
//           undefined, read data is always zero.
module pwm
   import pwm_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   pwm_if.slave  bus,
   output logic  pwm_out
);

`ifdef PWM_READBACK_EN
   localparam bit RB_EN = 1'b1;
`else
   localparam bit RB_EN = 1'b0;
`endif

   bus_state_e       state_q, state_d;
   logic [31:0]      shadow_q, shadow_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [31:0]      rd_val;
   logic             accept;
   reg_sel_e         sel;
   logic [CNT_W-1:0] cnt;

   logic             unused_addr;
   assign unused_addr = ^{bus.mem_addr[31:3], bus.mem_addr[1:0]};

   assign sel    = decode(bus.mem_addr[2]);
   assign rd_val = (sel == REG_CFG) ? shadow_q : {{(32-CNT_W){1'b0}}, cnt};

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      rdata_d  = '0;
      accept   = 1'b0;

      // The ACK state lasts one cycle and ignores mem_valid, so mem_ready
      // can never be high on two consecutive cycles.
      case (state_q)
         BUS_IDLE: begin
            if (bus.mem_valid) begin
               accept  = 1'b1;
               state_d = BUS_ACK;
            end
         end
         BUS_ACK:  state_d = BUS_IDLE;
         default:  state_d = BUS_IDLE;
      endcase

      if (accept) begin
         if (|bus.mem_wstrb) begin
            if (sel == REG_CFG)
               shadow_d = apply_wstrb(shadow_q, bus.mem_wdata, bus.mem_wstrb);
         end else begin
            rdata_d = RB_EN ? rd_val : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= BUS_IDLE;
         shadow_q <= CFG_RST;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         rdata_q  <= rdata_d;
      end
   end

   assign bus.mem_ready = (state_q == BUS_ACK);
   assign bus.mem_rdata = rdata_q;

   pwm_counter u_counter (
      .clk             (clk),
      .rst_n           (rst_n),
      .shadow_duty_i   (shadow_q[31:16]),
      .shadow_period_i (shadow_q[15:0]),
      .cnt_o           (cnt),
      .pwm_o           (pwm_out)
   );

endmodule

// File: tb/tb_pwm.sv
// tb/tb_pwm.sv - scoreboard testbench for the PWM block
module tb_pwm;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pwm_out;

   always #5 clk = ~clk;

   pwm_if bus ();

   pwm dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .pwm_out (pwm_out)
   );

   typedef struct {
      bit          chk;
      logic [31:0] lo;
      logic [31:0] hi;
      string       name;
   } exp_t;

   exp_t  sb_q[$];
   bit    pwm_q[$];
   string pwm_name = "pwm";
   int    checks = 0;
   int    errors = 0;
   bit    ready_prev = 1'b0;
   exp_t  mon_e;
   bit    mon_b;

   localparam logic [31:0] A_CFG = 32'h0;
   localparam logic [31:0] A_CNT = 32'h4;

   function automatic logic [31:0] rb(input logic [31:0] v);
`ifdef PWM_READBACK_EN
      return v;
`else
      return 32'h0 & v;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every acknowledge, checks pwm each cycle.
   always @(negedge clk) begin
      if (bus.mem_ready === 1'b1) begin
         check("ready_not_back_to_back", {31'b0, ready_prev}, 32'h0);
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: got ready=1 expected no transfer at %0t", $time);
         end else begin
            mon_e = sb_q.pop_front();
            if (mon_e.chk) begin
               checks++;
               if (bus.mem_rdata < mon_e.lo || bus.mem_rdata > mon_e.hi) begin
                  errors++;
                  $display("FAIL %s: got %h expected %h..%h", mon_e.name, bus.mem_rdata,
                           mon_e.lo, mon_e.hi);
               end
            end
         end
      end else begin
         check("rdata_idle_zero", bus.mem_rdata, 32'h0);
      end
      ready_prev = bus.mem_ready;
      if (pwm_q.size() > 0) begin
         mon_b = pwm_q.pop_front();
         check(pwm_name, {31'b0, pwm_out}, {31'b0, mon_b});
      end
   end

   task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input bit chk,
                           input logic [31:0] lo, input logic [31:0] hi, input string name);
      bit got;
      got = 1'b0;
      sb_q.push_back('{chk, lo, hi, name});
      @(posedge clk); #1;
      bus.mem_valid = 1'b1;
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
      bus.mem_wstrb = wstrb;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.mem_ready === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      bus.mem_valid = 1'b0;
      bus.mem_wstrb = 4'h0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no ready expected ready within 20 cycles", name);
         sb_q.delete();
      end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bus_xfer(addr, data, strb, 1'b0, 32'h0, 32'h0, "write");
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] want, input string name);
      bus_xfer(addr, 32'h0, 4'h0, 1'b1, want, want, name);
   endtask

   task automatic push_bits(input int n, input bit v);
      for (int i = 0; i < n; i++) pwm_q.push_back(v);
   endtask

   task automatic push_pattern(input int n_hi, input int n_lo, input int reps);
      for (int r = 0; r < reps; r++) begin
         push_bits(n_hi, 1'b1);
         push_bits(n_lo, 1'b0);
      end
   endtask

   task automatic drain();
      int i;
      i = 0;
      while ((pwm_q.size() != 0 || sb_q.size() != 0) && i < 300) begin
         @(posedge clk);
         i++;
      end
      if (pwm_q.size() != 0 || sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", pwm_q.size() + sb_q.size());
         pwm_q.delete();
         sb_q.delete();
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.mem_valid = 1'b0;
      bus.mem_addr  = 32'h0;
      bus.mem_wdata = 32'h0;
      bus.mem_wstrb = 4'h0;

      // Reset state
      repeat (10) @(posedge clk);
      #1;
      check("reset_ready", {31'b0, bus.mem_ready}, 32'h0);
      check("reset_rdata", bus.mem_rdata, 32'h0);
      check("reset_pwm", {31'b0, pwm_out}, 32'h0);
      rst_n = 1'b1;
      rd(A_CNT, rb(32'h0), "reset_cnt_read");
      drain();

      // Basic 3/8
      do_reset();
      wr(A_CFG, 32'h0003_0008, 4'hF);
      pwm_name = "pwm_basic";
      push_bits(2, 1'b0);
      push_pattern(3, 5, 2);
      bus_xfer(A_CNT, 32'h0, 4'h0, 1'b1, rb(32'h0), rb(32'h7), "basic_cnt_range");
      drain();

      // Handshake: valid high 2 / low 2
      do_reset();
      bus.mem_addr  = A_CFG;
      bus.mem_wdata = 32'h1000_2000;
      bus.mem_wstrb = 4'hF;
      for (int ph = 0; ph < 3; ph++) begin
         sb_q.push_back('{1'b0, 32'h0, 32'h0, "hs_write"});
         @(posedge clk); #1;
         bus.mem_valid = 1'b1;
         @(posedge clk); #1;
         check("hs_ready_rise", {31'b0, bus.mem_ready}, 32'h1);
         @(posedge clk); #1;
         check("hs_ready_drop", {31'b0, bus.mem_ready}, 32'h0);
         bus.mem_valid = 1'b0;
         @(posedge clk); #1;
         check("hs_ready_low", {31'b0, bus.mem_ready}, 32'h0);
      end
      bus.mem_wstrb = 4'h0;
      rd(A_CFG, rb(32'h1000_2000), "hs_cfg_read");
      drain();

      // Deferred update: 2/4 written mid-period while running 3/8
      do_reset();
      wr(A_CFG, 32'h0003_0008, 4'hF);
      wr(A_CFG, 32'h0002_0004, 4'hF);
      pwm_name = "pwm_defer";
      push_pattern(3, 5, 1);
      push_pattern(2, 2, 3);
      rd(A_CNT, rb(32'h2), "defer_cnt_read");
      rd(A_CFG, rb(32'h0002_0004), "defer_shadow_read");
      drain();

      // duty = 0
      do_reset();
      wr(A_CFG, 32'h0000_0008, 4'hF);
      pwm_name = "pwm_duty0";
      push_bits(20, 1'b0);
      drain();

      // duty >= period
      do_reset();
      wr(A_CFG, 32'hFFFF_0005, 4'hF);
      pwm_name = "pwm_full";
      push_bits(2, 1'b0);
      push_bits(15, 1'b1);
      drain();

      // period = 0, then immediate activation of a new value
      do_reset();
      wr(A_CFG, 32'h0003_0000, 4'hF);
      pwm_name = "pwm_period0";
      push_bits(10, 1'b0);
      rd(A_CNT, rb(32'h0), "period0_cnt_read");
      drain();
      wr(A_CFG, 32'h0001_0002, 4'hF);
      pwm_name = "pwm_period0_load";
      push_bits(2, 1'b0);
      push_pattern(1, 1, 5);
      drain();

      // Byte strobes, CNT write ignored
      do_reset();
      wr(A_CFG, 32'hAAAA_5555, 4'b0011);
      rd(A_CFG, rb(32'h0000_5555), "strb_low_read");
      wr(A_CFG, 32'h1234_FFFF, 4'b1100);
      rd(A_CFG, rb(32'h1234_5555), "strb_high_read");
      wr(A_CNT, 32'hFFFF_FFFF, 4'hF);
      rd(A_CFG, rb(32'h1234_5555), "cnt_write_ignored");
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
